// File: rtl/conv2d_window_stream_pkg.sv
// Shared width derivations and indexing helpers for the streaming 2-D convolution engine.
package conv_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Counter width with a floor of one bit so degenerate geometries still elaborate.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Full-precision product of one pixel and one coefficient.
  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Accumulator wide enough that summing all K*K products can never overflow.
  function automatic int acc_w(input int dw, input int cw, input int k);
    return dw + cw + clog2(k * k);
  endfunction

  // Flat coefficient index: row r (0 = oldest/top), column c (0 = oldest/left).
  function automatic int coef_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Line delays run at full row depth on the raw pixel stream, so each tap is
  // exactly one row older than its input and the window columns are kept in a
  // separate KxK register array. This keeps the tap alignment independent of K.
  function automatic int ld_depth(input int img_w);
    return img_w;
  endfunction

endpackage

// File: rtl/conv2d_window_stream_line_delay.sv
// Enabled shift delay: output is the sample accepted DEPTH enables ago.
module line_delay #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_d
);

  logic [DATA_W-1:0] r_sr [DEPTH];

  // Shift one position per accepted pixel; storage is data-only and never reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_d = r_sr[DEPTH-1];

endmodule

// File: rtl/conv2d_window_stream.sv
// Streaming KxK convolution: window build from line delays, per-frame coefficients,
// two-stage multiply / sum-shift-saturate pipeline, valid-region output only.
module conv2d_window_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 8,
  parameter int K      = 5,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [K*K*COEF_W-1:0] f_coeff,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     d_in,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  out_sat,
  output logic [DATA_W-1:0]     d_out
);

  localparam int NTAP   = K * K;
  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, K);
  localparam int CW     = cnt_w(IMG_W);
  localparam int RW     = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K1  = RW'(K - 1);

  function automatic logic [ACC_W-1:0] shr_fn(input logic [ACC_W-1:0] v);
    return v >> SHIFT;
  endfunction

  // Returns {sat, data}; clips to all ones when any bit above DATA_W is set.
  function automatic logic [DATA_W:0] sat_fn(input logic [ACC_W-1:0] v);
    if (|v[ACC_W-1:DATA_W]) return {1'b1, {DATA_W{1'b1}}};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [K*K*COEF_W-1:0] r_coef;
  logic [DATA_W-1:0]     r_win [K][K];

  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic                  w_fs;
  logic                  w_complete;
  logic                  w_last;
  logic [K*K*COEF_W-1:0] w_coef_use;
  logic [DATA_W-1:0]     w_tap [K];
  logic [DATA_W-1:0]     w_win [K][K];
  logic [PROD_W-1:0]     w_prod [NTAP];

  logic [PROD_W-1:0]     r_prod_p1 [NTAP];
  logic                  r_vld_p1;
  logic                  r_last_p1;

  logic [ACC_W-1:0]      w_acc;
  logic [ACC_W-1:0]      w_res;
  logic [DATA_W:0]       w_sat_dat;

  // Tap 0 is the live pixel; tap j is the same column j rows earlier.
  assign w_tap[0] = d_in;
  for (genvar j = 1; j < K; j++) begin : g_ld
    line_delay #(
      .DATA_W (DATA_W),
      .DEPTH  (ld_depth(IMG_W))
    ) u_ld (
      .clk  (clk),
      .i_en (in_valid),
      .i_d  (w_tap[j-1]),
      .o_d  (w_tap[j])
    );
  end

  // Position of the presented pixel, frame-start and window-complete decode.
  always_comb begin
    w_col      = in_sof ? '0 : r_col;
    w_row      = in_sof ? '0 : r_row;
    w_fs       = in_valid && (w_col == '0) && (w_row == '0);
    w_complete = in_valid && (w_row >= ROW_K1) && (w_col >= COL_K1);
    w_last     = w_complete && (w_row == ROW_MAX) && (w_col == COL_MAX);
    w_coef_use = w_fs ? f_coeff : r_coef;
  end

  // Next window: shift left one column, new right column from the taps (top row oldest).
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) w_win[r][c] = r_win[r][c+1];
      w_win[r][K-1] = w_tap[K-1-r];
    end
  end

  // Products of the incoming window against the coefficients in force for this pixel.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_prod[coef_idx(r, c, K)] = PROD_W'(w_win[r][c]) *
          PROD_W'(w_coef_use[coef_idx(r, c, K)*COEF_W +: COEF_W]);
      end
    end
  end

  // Raster counters and per-frame coefficient latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_coef <= '0;
    end else if (in_valid) begin
      if (w_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (w_row == ROW_MAX) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
      if (w_fs) r_coef <= f_coeff;
    end
  end

  // Window storage holds when no pixel is accepted; never reset.
  always_ff @(posedge clk) begin
    if (in_valid) r_win <= w_win;
  end

  // ---- stage p1: registered products ----
  // Product registers capture every cycle; only the valid/last bits are reset.
  always_ff @(posedge clk) begin
    r_prod_p1 <= w_prod;
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= w_complete;
      r_last_p1 <= w_last;
    end
  end

  // Sum of the registered products, then shift and clip.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NTAP; i++) w_acc = w_acc + ACC_W'(r_prod_p1[i]);
    w_res     = shr_fn(w_acc);
    w_sat_dat = sat_fn(w_res);
  end

  // ---- stage p2: output registers ----
  // Outputs update only on a valid result and otherwise hold their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      d_out     <= '0;
    end else begin
      out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        out_last <= r_last_p1;
        out_sat  <= w_sat_dat[DATA_W];
        d_out    <= w_sat_dat[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_conv2d_window_stream.sv
// Directed bench for conv2d_window_stream on a 4x4 image with a 3x3 kernel.
module tb_conv2d_window_stream;

  localparam int DW  = 12;
  localparam int CWD = 8;
  localparam int KK  = 3;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int CB  = KK * KK * CWD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CB-1:0] f_coeff = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] d_in = '0;

  logic          ov, ol, os;
  logic [DW-1:0] od;
  logic          ov_s, ol_s, os_s;
  logic [DW-1:0] od_s;

  conv2d_window_stream #(.DATA_W(DW), .COEF_W(CWD), .K(KK), .IMG_W(IW), .IMG_H(IH), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .f_coeff(f_coeff), .in_valid(in_valid), .in_sof(in_sof), .d_in(d_in),
    .out_valid(ov), .out_last(ol), .out_sat(os), .d_out(od)
  );

  conv2d_window_stream #(.DATA_W(DW), .COEF_W(CWD), .K(KK), .IMG_W(IW), .IMG_H(IH), .SHIFT(14)) dut_s (
    .clk(clk), .rst(rst), .f_coeff(f_coeff), .in_valid(in_valid), .in_sof(in_sof), .d_in(d_in),
    .out_valid(ov_s), .out_last(ol_s), .out_sat(os_s), .d_out(od_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of every result seen on the main instance, sampled on the falling edge.
  int            n_ev = 0;
  int            ev_cyc [64];
  logic [DW-1:0] ev_d   [64];
  logic          ev_s   [64];
  logic          ev_l   [64];
  logic [DW-1:0] ev_ds  [64];
  logic          ev_ss  [64];
  logic          ev_ls  [64];
  logic          ev_vs  [64];

  always @(negedge clk) begin
    if (ov && n_ev < 64) begin
      ev_cyc[n_ev] = cyc;
      ev_d[n_ev]   = od;
      ev_s[n_ev]   = os;
      ev_l[n_ev]   = ol;
      ev_ds[n_ev]  = od_s;
      ev_ss[n_ev]  = os_s;
      ev_ls[n_ev]  = ol_s;
      ev_vs[n_ev]  = ov_s;
      n_ev = n_ev + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int pc [16];
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CB-1:0] mk_coef(input bit centre, input logic [7:0] v);
    logic [CB-1:0] c;
    c = '0;
    for (int i = 0; i < KK * KK; i++) if (!centre || i == 4) c[i*CWD +: CWD] = v;
    return c;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [DW-1:0] v, input logic sof, input int idx);
    d_in     = v;
    in_sof   = sof;
    in_valid = 1'b1;
    pc[idx]  = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit ramp, input logic [DW-1:0] cv, input bit sof, input bit toggle);
    for (int i = 0; i < IW * IH; i++) begin
      px(ramp ? DW'(i) : cv, sof && (i == 0), i);
      if (toggle) idle(1);
    end
    idle(4);
  endtask

  // Four results of a frame: values, sat, last on the fourth only, two cycles after pixels 10,11,14,15.
  task automatic chk_frame(input string tag, input int b, input int e0, input int e1,
                           input int e2, input int e3, input logic esat);
    int e [4];
    int pidx [4];
    e    = '{e0, e1, e2, e3};
    pidx = '{10, 11, 14, 15};
    chk({tag, "_count"}, n_ev - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(ev_d[b+i]), e[i]);
      chk($sformatf("%s_sat%0d", tag, i), 32'(ev_s[b+i]), 32'(esat));
      chk($sformatf("%s_last%0d", tag, i), 32'(ev_l[b+i]), (i == 3) ? 1 : 0);
      chk($sformatf("%s_lat%0d", tag, i), ev_cyc[b+i], pc[pidx[i]] + 2);
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    rst = 1'b0;
    chk("rst_valid", 32'(ov), 0);
    chk("rst_last", 32'(ol), 0);
    chk("rst_sat", 32'(os), 0);
    chk("rst_dout", 32'(od), 0);

    // All-ones window sum, implicit first frame start after reset
    f_coeff = mk_coef(1'b0, 8'd1);
    base = n_ev;
    send_frame(1'b0, 12'd1, 1'b0, 1'b0);
    chk_frame("s1", base, 9, 9, 9, 9, 1'b0);
    chk("s1_hold_valid", 32'(ov), 0);
    chk("s1_hold_d", 32'(od), 9);
    chk("s1_hold_last", 32'(ol), 1);

    // Centre tap on a ramp, coefficients picked up at the implicit wrap
    f_coeff = mk_coef(1'b1, 8'd1);
    base = n_ev;
    send_frame(1'b1, '0, 1'b0, 1'b0);
    chk_frame("s2", base, 5, 6, 9, 10, 1'b0);

    // Same with in_valid toggling every cycle
    base = n_ev;
    send_frame(1'b1, '0, 1'b1, 1'b1);
    chk_frame("s3", base, 5, 6, 9, 10, 1'b0);

    // Saturation on the unshifted instance, shifted instance stays in range
    f_coeff = mk_coef(1'b0, 8'd255);
    base = n_ev;
    send_frame(1'b0, 12'd4095, 1'b1, 1'b0);
    chk_frame("s4a", base, 4095, 4095, 4095, 4095, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s4a_sh_vld%0d", i), 32'(ev_vs[base+i]), 1);
      chk($sformatf("s4a_sh_d%0d", i), 32'(ev_ds[base+i]), 573);
      chk($sformatf("s4a_sh_sat%0d", i), 32'(ev_ss[base+i]), 0);
    end
    base = n_ev;
    send_frame(1'b0, 12'd1, 1'b1, 1'b0);
    chk_frame("s4b", base, 2295, 2295, 2295, 2295, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s4b_sh_d%0d", i), 32'(ev_ds[base+i]), 0);
      chk($sformatf("s4b_sh_sat%0d", i), 32'(ev_ss[base+i]), 0);
    end
    chk("s4b_sh_last", 32'(ev_ls[base+3]), 1);

    // Reset right after the window-completing pixel 10 drops the in-flight result
    f_coeff = mk_coef(1'b1, 8'd1);
    base = n_ev;
    for (int i = 0; i <= 10; i++) px(DW'(i), i == 0, i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("s5_dropped", n_ev - base, 0);
    chk("s5_rst_dout", 32'(od), 0);
    chk("s5_rst_last", 32'(ol), 0);
    base = n_ev;
    send_frame(1'b1, '0, 1'b1, 1'b0);
    chk_frame("s5", base, 5, 6, 9, 10, 1'b0);

    // Mid-frame coefficient change, then mid-frame restart with in_sof
    base = n_ev;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) f_coeff = mk_coef(1'b0, 8'd1);
      px(DW'(i), i == 0, i);
    end
    idle(3);
    chk("s6a_count", n_ev - base, 2);
    chk("s6a_d0", 32'(ev_d[base]), 5);
    chk("s6a_d1", 32'(ev_d[base+1]), 6);
    chk("s6a_last0", 32'(ev_l[base]), 0);
    chk("s6a_last1", 32'(ev_l[base+1]), 0);
    chk("s6a_lat1", ev_cyc[base+1], pc[11] + 2);
    base = n_ev;
    send_frame(1'b1, '0, 1'b1, 1'b0);
    chk_frame("s6b", base, 45, 54, 81, 90, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
